button_press_classifier: RTL and testbench
==========================================

// Module: button_press_classifier
// PURPOSE
//   Front-end conditioner for the clock's three push buttons: INC, SET and SW.
//   Synchronises and debounces each raw button.
//   Classifies INC presses as short or long.
//   Emits single-cycle strobes inc_short / inc_long / set / sw that drive the mode FSM directly.
//   Sits between the board pins and the mode FSM.
// PARAMETERS
//   DEBOUNCE_CYCLES  4   consecutive stable cycles needed to accept a new level (board build: 1_000_000)
//   LONG_CYCLES      20  debounced-high cycles after which an INC press is long (board build: 50_000_000)
//   REPEAT_CYCLES    8   inc_long repeat period while held; used only with AUTO_REPEAT_EN
//   CNT_W            16  width of the debounce/hold/repeat counters; each *_CYCLES must be < 2**CNT_W
// PORTS
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   btn_inc_raw  in   1  raw INC button, active-high, asynchronous, bouncy
//   btn_set_raw  in   1  raw SET button, same properties as btn_inc_raw
//   btn_sw_raw   in   1  raw SW button, same properties as btn_inc_raw
//   inc_short    out  1  1-cycle strobe: INC released before reaching long
//   inc_long     out  1  1-cycle strobe: INC held LONG_CYCLES (plus repeats if enabled)
//   set          out  1  1-cycle strobe on debounced SET press
//   sw           out  1  1-cycle strobe on debounced SW press
// BEHAVIOUR
//   Reset
//     - rst_n low clears: all synchroniser flops, debounced levels, counters and outputs to 0.
//     - INC FSM goes to IDLE.
//     - Effect is immediate and asynchronous; release is synchronous to clk.
//   Synchroniser
//     - Two flops per button.
//   Debounce (per button, independent)
//     - Counter runs while the synchronised level differs from the debounced level.
//     - Counter clears on any cycle where the two levels match.
//     - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
//     - Rise and fall are treated symmetrically.
//   set / sw
//     - Registered strobe, high for exactly 1 cycle, in the cycle after the debounced rise.
//     - No strobe on release.
//     - Holding the button never re-strobes.
//   INC FSM (states IDLE, PRESSED, HELD)
//     - IDLE -> PRESSED on debounced rise; hold counter cleared to 0.
//     - PRESSED: hold counter +1 per cycle.
//       - Debounced fall -> inc_short high next cycle for 1 cycle, -> IDLE.
//       - hold counter == LONG_CYCLES-1 -> inc_long high next cycle for 1 cycle, -> HELD.
//       - inc_long therefore fires LONG_CYCLES cycles after entering PRESSED.
//     - HELD: debounced fall -> IDLE, no strobe.
//   Mutual exclusion
//     - inc_short and inc_long never assert in the same cycle.
//     - Exactly one of them fires per press (absent AUTO_REPEAT_EN).
//   Counter saturation
//     - Counters saturate and never wrap.
//     - A long hold cannot alias to a short press.
//   Simultaneous buttons
//     - Fully independent; set, sw and inc strobes may coincide.
//     - The downstream FSM arbitrates.
//   Reset mid-press
//     - The in-flight press is discarded.
//     - If the button is still held after reset, it is re-debounced and treated as a fresh press.
//   Latency
//     - Raw edge to strobe: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//     - inc_long additionally requires LONG_CYCLES.
// CONFIGURATION
//   AUTO_REPEAT_EN defined
//     - In HELD, a repeat counter clears on entry.
//     - inc_long strobes again every REPEAT_CYCLES cycles until the debounced fall.
//     - Release mid-period emits nothing.
//   AUTO_REPEAT_EN undefined
//     - HELD only waits for release; at most one inc_long per press.
//     - Repeat counter and REPEAT_CYCLES logic are absent.
// TESTING (defaults)
//   1. Bounce rejection
//      - Stimulus: btn_set_raw toggles every cycle for 6 cycles, then held high 12 cycles.
//      - Required: exactly one set pulse, 1 cycle wide; sw/inc_* stay 0.
//   2. Glitch rejection
//      - Stimulus: btn_inc_raw high for 3 cycles, then low.
//      - Required: no strobe of any kind.
//   3. Short press
//      - Stimulus: btn_inc_raw high for 10 cycles.
//      - Required: one inc_short, asserted 2+4+1 cycles after raw fall; inc_long never asserts.
//   4. Long press
//      - Stimulus: btn_inc_raw high for 50 cycles.
//      - Without AUTO_REPEAT_EN: one inc_long, 20 cycles after PRESSED entry; no inc_short.
//      - With AUTO_REPEAT_EN: 4 inc_long pulses spaced exactly 8 cycles apart; no inc_short.
//   5. Reset mid-hold
//      - Stimulus: btn_inc_raw high 30 cycles; rst_n low at cycle 15 for 2 cycles.
//      - Required: all outputs 0 during reset, no inc_long, then exactly one inc_short after release.
//   6. Simultaneous SET and SW
//      - Stimulus: btn_set_raw and btn_sw_raw rise in the same cycle.
//      - Required: set and sw pulse in the same cycle, each 1 cycle wide.

Source files
------------

// File: rtl/button_press_classifier.sv
// Button front end: synchronises and debounces INC/SET/SW, then emits single-cycle strobes.
// Optional feature macro: AUTO_REPEAT_EN (repeating inc_long while INC stays held).

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  // The level only flips after the synchronised input has disagreed with it
  // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt >= DB_LAST) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module button_press_classifier #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 20,
  parameter int REPEAT_CYCLES   = 8,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_inc_raw,
  input  logic btn_set_raw,
  input  logic btn_sw_raw,
  output logic inc_short,
  output logic inc_long,
  output logic set,
  output logic sw
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } inc_state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);

  logic       inc_db;
  logic       set_db;
  logic       sw_db;
  logic       inc_q;
  logic       set_q;
  logic       sw_q;
  inc_state_t state;
  logic [CNT_W-1:0] hold_cnt;
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_cnt;
`endif

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_inc_raw),
    .level (inc_db)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_set (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_set_raw),
    .level (set_db)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_sw (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_sw_raw),
    .level (sw_db)
  );

  // SET and SW only care about the press edge; release and hold are silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_q <= 1'b0;
      sw_q  <= 1'b0;
      set   <= 1'b0;
      sw    <= 1'b0;
    end else begin
      set_q <= set_db;
      sw_q  <= sw_db;
      set   <= set_db & ~set_q;
      sw    <= sw_db & ~sw_q;
    end
  end

  // Leaving PRESSED on either the fall or the long threshold is what keeps
  // inc_short and inc_long mutually exclusive for a given press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      inc_q     <= 1'b0;
      inc_short <= 1'b0;
      inc_long  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      inc_q     <= inc_db;
      inc_short <= 1'b0;
      inc_long  <= 1'b0;
      case (state)
        IDLE: begin
          if (inc_db && !inc_q) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (!inc_db) begin
            inc_short <= 1'b1;
            state     <= IDLE;
          end else if (hold_cnt >= HOLD_LAST) begin
            inc_long <= 1'b1;
            state    <= HELD;
`ifdef AUTO_REPEAT_EN
            rep_cnt  <= '0;
`endif
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!inc_db) begin
            state <= IDLE;
`ifdef AUTO_REPEAT_EN
          end else if (rep_cnt >= REP_LAST) begin
            inc_long <= 1'b1;
            rep_cnt  <= '0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier: bounce, glitch, short/long press, reset mid-hold, coincident buttons.
// Honours AUTO_REPEAT_EN in the long-press expectations.

module tb_button_press_classifier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_inc_raw = 1'b0;
  logic btn_set_raw = 1'b0;
  logic btn_sw_raw = 1'b0;
  logic inc_short;
  logic inc_long;
  logic set;
  logic sw;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int n_set = 0;
  int n_sw = 0;
  int n_short = 0;
  int n_long = 0;
  int n_both = 0;
  int last_set = -1;
  int last_sw = -1;
  int last_short = -1;
  int last_long = -1;
  int long_at [16];

  button_press_classifier dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_inc_raw (btn_inc_raw),
    .btn_set_raw (btn_set_raw),
    .btn_sw_raw  (btn_sw_raw),
    .inc_short   (inc_short),
    .inc_long    (inc_long),
    .set         (set),
    .sw          (sw)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse tally sampled on the falling edge, stamped with the posedge count.
  always @(negedge clk) begin
    if (set) begin n_set++; last_set = cyc; end
    if (sw) begin n_sw++; last_sw = cyc; end
    if (inc_short) begin n_short++; last_short = cyc; end
    if (inc_long) begin long_at[n_long % 16] = cyc; n_long++; last_long = cyc; end
    if (inc_short && inc_long) n_both++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if ({inc_short, inc_long, set, sw} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000", {inc_short, inc_long, set, sw});
    end
    rst_n = 1'b1;
    tick(8);
    checks++;
    if (n_set + n_sw + n_short + n_long !== 0) begin
      errors++;
      $display("[TB] FAIL reset_idle_pulses: got %0d expected 0", n_set + n_sw + n_short + n_long);
    end
  endtask

  task automatic test_bounce();
    int start, s0, w0, sh0, l0;
    start = cyc; s0 = n_set; w0 = n_sw; sh0 = n_short; l0 = n_long;
    for (int i = 0; i < 6; i++) begin
      btn_set_raw = (i % 2 == 0);
      tick(1);
    end
    btn_set_raw = 1'b1;
    tick(12);
    btn_set_raw = 1'b0;
    tick(20);
    checks++;
    if (n_set - s0 !== 1) begin
      errors++;
      $display("[TB] FAIL bounce_set_count: got %0d expected 1", n_set - s0);
    end
    checks++;
    if (last_set !== start + 13) begin
      errors++;
      $display("[TB] FAIL bounce_set_cycle: got %0d expected %0d", last_set, start + 13);
    end
    checks++;
    if ((n_sw - w0) + (n_short - sh0) + (n_long - l0) !== 0) begin
      errors++;
      $display("[TB] FAIL bounce_other_pulses: got %0d expected 0", (n_sw - w0) + (n_short - sh0) + (n_long - l0));
    end
  endtask

  task automatic test_glitch();
    int s0, w0, sh0, l0;
    s0 = n_set; w0 = n_sw; sh0 = n_short; l0 = n_long;
    btn_inc_raw = 1'b1;
    tick(3);
    btn_inc_raw = 1'b0;
    tick(40);
    checks++;
    if (n_short - sh0 !== 0) begin
      errors++;
      $display("[TB] FAIL glitch_short: got %0d expected 0", n_short - sh0);
    end
    checks++;
    if (n_long - l0 !== 0) begin
      errors++;
      $display("[TB] FAIL glitch_long: got %0d expected 0", n_long - l0);
    end
    checks++;
    if ((n_set - s0) + (n_sw - w0) !== 0) begin
      errors++;
      $display("[TB] FAIL glitch_set_sw: got %0d expected 0", (n_set - s0) + (n_sw - w0));
    end
  endtask

  task automatic test_short_press();
    int start, sh0, l0;
    start = cyc; sh0 = n_short; l0 = n_long;
    btn_inc_raw = 1'b1;
    tick(10);
    btn_inc_raw = 1'b0;
    tick(30);
    checks++;
    if (n_short - sh0 !== 1) begin
      errors++;
      $display("[TB] FAIL short_count: got %0d expected 1", n_short - sh0);
    end
    checks++;
    if (last_short !== start + 17) begin
      errors++;
      $display("[TB] FAIL short_cycle: got %0d expected %0d", last_short, start + 17);
    end
    checks++;
    if (n_long - l0 !== 0) begin
      errors++;
      $display("[TB] FAIL short_no_long: got %0d expected 0", n_long - l0);
    end
  endtask

  task automatic test_long_press();
    int start, sh0, l0;
    start = cyc; sh0 = n_short; l0 = n_long;
    btn_inc_raw = 1'b1;
    tick(50);
    btn_inc_raw = 1'b0;
    tick(40);
`ifdef AUTO_REPEAT_EN
    checks++;
    if (n_long - l0 !== 4) begin
      errors++;
      $display("[TB] FAIL long_count: got %0d expected 4", n_long - l0);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (long_at[(l0 + k) % 16] !== start + 27 + 8 * k) begin
        errors++;
        $display("[TB] FAIL long_cycle_%0d: got %0d expected %0d", k, long_at[(l0 + k) % 16], start + 27 + 8 * k);
      end
    end
`else
    checks++;
    if (n_long - l0 !== 1) begin
      errors++;
      $display("[TB] FAIL long_count: got %0d expected 1", n_long - l0);
    end
    checks++;
    if (last_long !== start + 27) begin
      errors++;
      $display("[TB] FAIL long_cycle: got %0d expected %0d", last_long, start + 27);
    end
`endif
    checks++;
    if (n_short - sh0 !== 0) begin
      errors++;
      $display("[TB] FAIL long_no_short: got %0d expected 0", n_short - sh0);
    end
  endtask

  task automatic test_reset_mid_hold();
    int start, sh0, l0;
    start = cyc; sh0 = n_short; l0 = n_long;
    btn_inc_raw = 1'b1;
    tick(15);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({inc_short, inc_long, set, sw} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midreset_outputs_a: got %b expected 0000", {inc_short, inc_long, set, sw});
    end
    tick(1);
    checks++;
    if ({inc_short, inc_long, set, sw} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midreset_outputs_b: got %b expected 0000", {inc_short, inc_long, set, sw});
    end
    tick(1);
    rst_n = 1'b1;
    tick(13);
    btn_inc_raw = 1'b0;
    tick(30);
    checks++;
    if (n_long - l0 !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_no_long: got %0d expected 0", n_long - l0);
    end
    checks++;
    if (n_short - sh0 !== 1) begin
      errors++;
      $display("[TB] FAIL midreset_short_count: got %0d expected 1", n_short - sh0);
    end
    checks++;
    if (last_short !== start + 37) begin
      errors++;
      $display("[TB] FAIL midreset_short_cycle: got %0d expected %0d", last_short, start + 37);
    end
  endtask

  task automatic test_simultaneous();
    int start, s0, w0;
    start = cyc; s0 = n_set; w0 = n_sw;
    btn_set_raw = 1'b1;
    btn_sw_raw = 1'b1;
    tick(12);
    btn_set_raw = 1'b0;
    btn_sw_raw = 1'b0;
    tick(20);
    checks++;
    if (n_set - s0 !== 1) begin
      errors++;
      $display("[TB] FAIL simul_set_count: got %0d expected 1", n_set - s0);
    end
    checks++;
    if (n_sw - w0 !== 1) begin
      errors++;
      $display("[TB] FAIL simul_sw_count: got %0d expected 1", n_sw - w0);
    end
    checks++;
    if (last_set !== start + 7) begin
      errors++;
      $display("[TB] FAIL simul_set_cycle: got %0d expected %0d", last_set, start + 7);
    end
    checks++;
    if (last_sw !== start + 7) begin
      errors++;
      $display("[TB] FAIL simul_sw_cycle: got %0d expected %0d", last_sw, start + 7);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (n_both !== 0) begin
      errors++;
      $display("[TB] FAIL short_long_overlap: got %0d expected 0", n_both);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_glitch();
    test_short_press();
    test_long_press();
    test_reset_mid_hold();
    test_simultaneous();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
